// File: rtl/line_fill_wb_ctrl.sv
// ----------------------------------------------------------------------------
// line_fill_wb_ctrl
//
// Miss engine that sits between a 4-way set-associative cache and a banked
// main memory. One line request is taken per handshake. A request may write
// back a victim line, refill a line, or do both (writeback first). Every line
// transfer is split into one 32-bit beat per memory bank. Refill beats are
// reassembled into a full line and handed back to the cache as a one-cycle
// response pulse.
//
// Line word mapping: bank k holds line bits [BLOCK_SIZE-1-k*BANK_WORD_SIZE -: BANK_WORD_SIZE].
//   bank 0 = [127:96], bank 1 = [95:64], bank 2 = [63:32], bank 3 = [31:0].
//
// Handshake: a request transfers on the rising edge where both i_req_valid and
// o_req_ready are high. o_req_ready is high only in IDLE. All request fields
// are captured on that edge, so the cache may change them afterwards. Requests
// presented while busy are not queued. The response (o_resp_valid) is a single
// cycle pulse with no backpressure; o_resp_data is only meaningful during it.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous reset, active low
//   i_req_valid      request present
//   o_req_ready      engine idle and able to accept
//   i_req_wb         request includes writeback of the victim line
//   i_req_fill       request includes refill of a line
//   i_req_wb_addr    victim line address {tag,index}
//   i_req_wb_data    victim line data
//   i_req_fill_addr  refill line address {tag,index}
//   o_resp_valid     one-cycle completion pulse
//   o_resp_data      refilled line (0 for writeback-only / no-op requests)
//   o_busy           high in every state except IDLE
//   o_mem_en         memory beat strobe
//   o_mem_we         1 = write beat, 0 = read beat
//   o_mem_bank       bank select, equal to the beat index
//   o_mem_addr       bank word address
//   o_mem_wdata      write beat data
//   i_mem_rdata      read data, valid exactly one cycle after a read beat
//   o_dbg_state      current FSM state (IDLE=0, WB=1, RD=2, RD_WAIT=3, RESP=4)
// ----------------------------------------------------------------------------
module line_fill_wb_ctrl #(
    parameter int NO_OF_BANKS     = 4,
    parameter int BANK_SEL_BITS   = 2,
    parameter int BANK_ADDR_WIDTH = 8,
    parameter int BANK_WORD_SIZE  = 32,
    parameter int BLOCK_SIZE      = 128
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_wb,
    input  logic                       i_req_fill,
    input  logic [BANK_ADDR_WIDTH-1:0] i_req_wb_addr,
    input  logic [BLOCK_SIZE-1:0]      i_req_wb_data,
    input  logic [BANK_ADDR_WIDTH-1:0] i_req_fill_addr,
    output logic                       o_resp_valid,
    output logic [BLOCK_SIZE-1:0]      o_resp_data,
    output logic                       o_busy,
    output logic                       o_mem_en,
    output logic                       o_mem_we,
    output logic [BANK_SEL_BITS-1:0]   o_mem_bank,
    output logic [BANK_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [BANK_WORD_SIZE-1:0]  o_mem_wdata,
    input  logic [BANK_WORD_SIZE-1:0]  i_mem_rdata,
    output logic [2:0]                 o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WB      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [BANK_SEL_BITS-1:0] LAST_BEAT = BANK_SEL_BITS'(NO_OF_BANKS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                       r_state;
    state_t                       w_next_state;
    logic [BANK_SEL_BITS-1:0]     r_beat;
    logic                         r_fill_pend;
    logic [BANK_ADDR_WIDTH-1:0]   r_wb_addr;
    logic [BANK_ADDR_WIDTH-1:0]   r_fill_addr;
    logic [BLOCK_SIZE-1:0]        r_wb_data;
    logic [BLOCK_SIZE-1:0]        r_line;

    logic                         w_accept;
    logic                         w_last_beat;
    logic                         w_cap_en;
    logic [BANK_SEL_BITS-1:0]     w_cap_idx;
    logic [BANK_WORD_SIZE-1:0]    w_victim_word;

    assign w_accept    = (r_state == ST_IDLE) && i_req_valid;
    assign w_last_beat = (r_beat == LAST_BEAT);

    // Read data lags the read beat by one cycle, so during RD beat b the
    // returning word belongs to beat b-1; the final word arrives in RD_WAIT.
    assign w_cap_en  = ((r_state == ST_RD) && (r_beat != '0)) || (r_state == ST_RD_WAIT);
    assign w_cap_idx = (r_state == ST_RD_WAIT) ? LAST_BEAT : (r_beat - 1'b1);

    // Victim word for the current writeback beat.
    always_comb begin
        w_victim_word = '0;
        for (int k = 0; k < NO_OF_BANKS; k++) begin
            if (r_beat == BANK_SEL_BITS'(k)) begin
                w_victim_word = r_wb_data[BLOCK_SIZE-1-k*BANK_WORD_SIZE -: BANK_WORD_SIZE];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_wb) begin
                        w_next_state = ST_WB;
                    end else if (i_req_fill) begin
                        w_next_state = ST_RD;
                    end else begin
                        // Neither writeback nor fill: acknowledge immediately.
                        w_next_state = ST_RESP;
                    end
                end
            end
            ST_WB: begin
                if (w_last_beat) begin
                    w_next_state = r_fill_pend ? ST_RD : ST_RESP;
                end
            end
            ST_RD: begin
                if (w_last_beat) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: w_next_state = ST_RESP;
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs (Moore, decoded from state and beat counter)
    // ------------------------------------------------------------------
    always_comb begin
        o_req_ready  = 1'b0;
        o_busy       = 1'b1;
        o_resp_valid = 1'b0;
        o_resp_data  = '0;
        o_mem_en     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_bank   = '0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
            end
            ST_WB: begin
                o_mem_en    = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_bank  = r_beat;
                o_mem_addr  = r_wb_addr;
                o_mem_wdata = w_victim_word;
            end
            ST_RD: begin
                o_mem_en   = 1'b1;
                o_mem_bank = r_beat;
                o_mem_addr = r_fill_addr;
            end
            ST_RD_WAIT: begin
                // Waiting for the last read word; memory bus stays quiet.
            end
            ST_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_data  = r_line;
            end
            default: begin
                o_req_ready = 1'b0;
            end
        endcase
    end

    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // Datapath: request capture, beat counter, line assembly
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat      <= '0;
            r_fill_pend <= 1'b0;
            r_wb_addr   <= '0;
            r_fill_addr <= '0;
            r_wb_data   <= '0;
            r_line      <= '0;
        end else begin
            if (w_accept) begin
                r_fill_pend <= i_req_fill;
                r_wb_addr   <= i_req_wb_addr;
                r_fill_addr <= i_req_fill_addr;
                r_wb_data   <= i_req_wb_data;
                // Cleared so writeback-only and no-op responses return zero.
                r_line      <= '0;
            end

            // The counter runs only during beat phases; it naturally wraps
            // from the last beat back to 0 at each phase change.
            if ((r_state == ST_WB) || (r_state == ST_RD)) begin
                r_beat <= r_beat + 1'b1;
            end else begin
                r_beat <= '0;
            end

            if (w_cap_en) begin
                for (int k = 0; k < NO_OF_BANKS; k++) begin
                    if (w_cap_idx == BANK_SEL_BITS'(k)) begin
                        r_line[BLOCK_SIZE-1-k*BANK_WORD_SIZE -: BANK_WORD_SIZE] <= i_mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_line_fill_wb_ctrl.sv
// Testbench for line_fill_wb_ctrl: banked memory model, request driver,
// beat scoreboard and response checks against a transaction-level model.
module tb_line_fill_wb_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wb = 1'b0;
  logic         req_fill = 1'b0;
  logic [7:0]   req_wb_addr = '0;
  logic [127:0] req_wb_data = '0;
  logic [7:0]   req_fill_addr = '0;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         busy;
  logic         mem_en;
  logic         mem_we;
  logic [1:0]   mem_bank;
  logic [7:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic [2:0]   dbg_state;

  line_fill_wb_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_wb        (req_wb),
    .i_req_fill      (req_fill),
    .i_req_wb_addr   (req_wb_addr),
    .i_req_wb_data   (req_wb_data),
    .i_req_fill_addr (req_fill_addr),
    .o_resp_valid    (resp_valid),
    .o_resp_data     (resp_data),
    .o_busy          (busy),
    .o_mem_en        (mem_en),
    .o_mem_we        (mem_we),
    .o_mem_bank      (mem_bank),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- banked memory model (with backdoor preload) ----------------
  logic [31:0] mem [4][256];
  logic        bd_en = 1'b0;
  logic [1:0]  bd_bank = '0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_bank][bd_addr] <= bd_data;
    end else if (mem_en && mem_we) begin
      mem[mem_bank][mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= mem[mem_bank][mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [42:0] exp_q[$];  // {we, bank, addr, wdata}

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [42:0] mk_beat(input logic we, input logic [1:0] bank,
                                          input logic [7:0] addr, input logic [31:0] data);
    return {we, bank, addr, (we ? data : 32'h0)};
  endfunction

  // Per-cycle bus monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_not_busy", 128'(req_ready), 128'(!busy));
      if (resp_valid) check("resp_excl_ready", 128'(req_ready), 128'(0));
      if (mem_en) begin
        logic [43:0] e;
        e = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 44'h0;
        check("mem_beat", 128'({1'b1, mk_beat(mem_we, mem_bank, mem_addr, mem_wdata)}), 128'(e));
      end else begin
        check("mem_idle_zero", 128'({mem_we, mem_bank, mem_addr, mem_wdata}), 128'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bd_write(input logic [1:0] b, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_bank = b; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // Reference model: the engine performs all writeback beats (bank 0..3) then
  // all read beats, and answers 1 + 4*wb + 5*fill cycles after acceptance.
  task automatic do_req(input logic wb, input logic fill, input logic [7:0] wa,
                        input logic [127:0] wd, input logic [7:0] fa, input bit hold);
    logic [127:0] exp_line;
    int exp_lat;
    int cyc;
    bit got;
    exp_line = '0;
    for (int k = 0; k < 4; k++) begin
      if (wb) exp_q.push_back(mk_beat(1'b1, 2'(k), wa, wd[127-32*k -: 32]));
    end
    for (int k = 0; k < 4; k++) begin
      if (fill) begin
        exp_q.push_back(mk_beat(1'b0, 2'(k), fa, 32'h0));
        exp_line[127-32*k -: 32] = (wb && wa == fa) ? wd[127-32*k -: 32] : mem[k][fa];
      end
    end
    exp_lat = 1 + (wb ? 4 : 0) + (fill ? 5 : 0);

    @(negedge clk);
    check("ready_before_req", 128'(req_ready), 128'(1));
    req_wb = wb; req_fill = fill; req_wb_addr = wa; req_wb_data = wd; req_fill_addr = fa;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble fields to confirm they were latched; optionally keep valid up.
    req_wb = 1'($urandom); req_fill = 1'($urandom);
    req_wb_addr = 8'($urandom); req_fill_addr = 8'($urandom);
    req_wb_data = {$urandom, $urandom, $urandom, $urandom};
    req_valid = hold;

    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (hold && !resp_valid) check("busy_no_ready", 128'(req_ready), 128'(0));
      if (resp_valid) begin
        got = 1;
        check("latency", 128'(cyc), 128'(exp_lat));
        check("resp_data", resp_data, exp_line);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("resp_seen", 128'(got), 128'(1));
    @(negedge clk);
    check("single_pulse", 128'(resp_valid), 128'(0));
    check("ready_after", 128'(req_ready), 128'(1));
    check("beats_drained", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic abort_fill(input logic [7:0] fa);
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_beat(1'b0, 2'(k), fa, 32'h0));
    @(negedge clk);
    req_wb = 1'b0; req_fill = 1'b1; req_fill_addr = fa; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);  // RD beats 0, 1, 2
    check("abort_at_beat2", 128'(mem_bank), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_en", 128'(mem_en), 128'(0));
    check("abort_ready", 128'(req_ready), 128'(1));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_resp", 128'(resp_valid), 128'(0));
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_resp", 128'(resp_valid), 128'(0));
      check("abort_mem_quiet", 128'({mem_en, mem_we, mem_bank, mem_addr, mem_wdata}), 128'(0));
    end
    #2 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_data", resp_data, 128'(0));
    check("rst_mem", 128'({mem_en, mem_we, mem_bank, mem_addr, mem_wdata}), 128'(0));
    #2 rst_n = 1'b1;

    // Preload a small region of memory with random words
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 4; b++)
        bd_write(2'(b), 8'(a), $urandom);
    bd_write(2'd0, 8'h05, 32'h11111111);
    bd_write(2'd1, 8'h05, 32'h22222222);
    bd_write(2'd2, 8'h05, 32'h33333333);
    bd_write(2'd3, 8'h05, 32'h44444444);

    // Directed: fill, writeback, wb+fill, no-op
    do_req(1'b0, 1'b1, 8'h00, 128'h0, 8'h05, 1'b0);
    do_req(1'b1, 1'b0, 8'h3C, 128'hDEADBEEF_BAADF00D_01234567_89ABCDEF, 8'h00, 1'b0);
    do_req(1'b1, 1'b1, 8'h3C, 128'hDEADBEEF_BAADF00D_01234567_89ABCDEF, 8'h05, 1'b0);
    do_req(1'b0, 1'b0, 8'h12, 128'h0, 8'h34, 1'b0);

    // Busy rejection: valid held high across the whole transfer
    do_req(1'b0, 1'b1, 8'h00, 128'h0, 8'h05, 1'b1);

    // Readback of the writeback target from the directed wb
    do_req(1'b0, 1'b1, 8'h00, 128'h0, 8'h3C, 1'b0);

    // Abort during RD beat 2, then a fresh fill
    abort_fill(8'h05);
    do_req(1'b0, 1'b1, 8'h00, 128'h0, 8'h05, 1'b0);

    // Randomized traffic over a small address window (forces wb/fill collisions)
    for (int i = 0; i < 40; i++) begin
      logic [7:0] wa;
      logic [7:0] fa;
      wa = 8'($urandom_range(0, 7));
      fa = (i % 3 == 0) ? wa : 8'($urandom_range(0, 7));
      do_req(1'($urandom), 1'($urandom), wa, {$urandom, $urandom, $urandom, $urandom},
             fa, bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
